// File: rtl/tinyriscv_pkg.sv
// Shared core definitions used by the instruction-fetch unit.
package tinyriscv_pkg;

  localparam int IF_ADDR_W          = 32;
  localparam int IF_DATA_W          = 32;
  localparam int IF_DEPTH           = 4;
  localparam int IF_MAX_OUTSTANDING = 2;

  // addi x0, x0, 0 -- presented to decode whenever no instruction is valid
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // One buffered fetch: the instruction together with the address it came from
  typedef struct packed {
    logic [IF_ADDR_W-1:0] addr;
    logic [IF_DATA_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset, synchronous clear and occupancy count.
// Push and pop in the same cycle both take effect, including when full.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage write port
  // NOTE: the data array has no reset; entries are only observed once count marks them valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally
  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch unit: pipelined word fetches on a req/gnt/rvalid bus,
// a small buffer of (address, instruction) pairs and a valid/ready port to decode.
// Redirects flush the buffer and retire stale in-flight responses via a discard count.
module if_prefetch
  import tinyriscv_pkg::*;
#(
  parameter int                ADDR_W          = IF_ADDR_W,
  parameter int                DATA_W          = IF_DATA_W,
  parameter int                DEPTH           = IF_DEPTH,
  parameter int                MAX_OUTSTANDING = IF_MAX_OUTSTANDING,
  parameter logic [ADDR_W-1:0] RESET_ADDR      = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              jtag_reset_flag_i,
  input  logic              halt_i,
  output logic              rib_pc_req_o,
  output logic [ADDR_W-1:0] rib_pc_addr_o,
  input  logic              rib_pc_gnt_i,
  input  logic              rib_pc_rvalid_i,
  input  logic [DATA_W-1:0] rib_pc_data_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = CW + 1;
  localparam int EW = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [OW-1:0]     outstanding;
  logic [OW-1:0]     outstanding_nxt;
  logic [OW-1:0]     discard;
  logic [OW-1:0]     live_outstanding;

  logic              flush;
  logic [ADDR_W-1:0] target;
  logic              credit_ok;
  logic              gnt_fire;
  logic              resp_push;
  logic              fifo_pop;
  logic [EW-1:0]     fifo_wdata;
  logic [EW-1:0]     fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_inst;

  // Redirect target: JTAG restart outranks a jump; low two bits dropped to stay word aligned
  always_comb begin
    target      = jtag_reset_flag_i ? RESET_ADDR : jump_addr_i;
    target[1:0] = 2'b00;
  end

  assign flush            = jump_flag_i || jtag_reset_flag_i;
  assign live_outstanding = outstanding - discard;

  // A request is only issued if its response is guaranteed a FIFO slot, so pushes never meet a full buffer
  assign credit_ok = !fifo_full &&
                     ((SW'(fifo_count) + SW'(live_outstanding)) < SW'(DEPTH));

  assign rib_pc_req_o  = !rst && !halt_i && !flush &&
                         (outstanding < OW'(MAX_OUTSTANDING)) && credit_ok;
  assign rib_pc_addr_o = fetch_pc;
  assign gnt_fire      = rib_pc_req_o && rib_pc_gnt_i;

  // Responses while discard is non-zero belong to an abandoned path and are dropped
  assign resp_push = rib_pc_rvalid_i && (discard == '0) && !flush;

  // In-flight count after this cycle's grant and response
  always_comb begin
    outstanding_nxt = outstanding;
    case ({gnt_fire, rib_pc_rvalid_i})
      2'b10:   outstanding_nxt = outstanding + OW'(1);
      2'b01:   outstanding_nxt = outstanding - OW'(1);
      default: outstanding_nxt = outstanding;
    endcase
  end

  // Fetch/response address tracking, in-flight and discard counters
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_ADDR;
      resp_pc     <= RESET_ADDR;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (flush) begin
        // Every request still in flight after this cycle was issued on the old path
        fetch_pc <= target;
        resp_pc  <= target;
        discard  <= outstanding_nxt;
      end else begin
        if (gnt_fire)  fetch_pc <= fetch_pc + ADDR_W'(4);
        if (resp_push) resp_pc  <= resp_pc + ADDR_W'(4);
        if (rib_pc_rvalid_i && (discard != '0)) discard <= discard - OW'(1);
      end
    end
  end

  // Entry layout matches fetch_entry_t: address in the upper field, instruction below
  assign fifo_wdata = {resp_pc, rib_pc_data_i};
  assign head_addr  = fifo_rdata[DATA_W +: ADDR_W];
  assign head_inst  = fifo_rdata[DATA_W-1:0];

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (resp_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Decode port: nothing is offered in a redirect cycle; an idle port shows a NOP at the next expected address
  assign inst_valid_o = !rst && !flush && !fifo_empty;
  assign inst_o       = inst_valid_o ? head_inst : DATA_W'(INST_NOP);
  assign inst_addr_o  = inst_valid_o ? head_addr : resp_pc;
  assign fifo_pop     = inst_valid_o && inst_ready_i;

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: directed scenarios followed by a randomized run.
// The bus model answers requests in order with a configurable latency; the reference
// model is simply "the next instruction decode should see", advanced by 4 per pop and
// reloaded on every redirect.
module tb_if_prefetch;
  import tinyriscv_pkg::*;

  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RST_ADDR = 32'h0;

  logic        clk;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        jtag_reset_flag_i;
  logic        halt_i;
  logic        rib_pc_req_o;
  logic [31:0] rib_pc_addr_o;
  logic        rib_pc_gnt_i;
  logic        rib_pc_rvalid_i;
  logic [31:0] rib_pc_data_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i;

  if_prefetch #(
    .ADDR_W          (32),
    .DATA_W          (32),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_ADDR      (RST_ADDR)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .jump_flag_i       (jump_flag_i),
    .jump_addr_i       (jump_addr_i),
    .jtag_reset_flag_i (jtag_reset_flag_i),
    .halt_i            (halt_i),
    .rib_pc_req_o      (rib_pc_req_o),
    .rib_pc_addr_o     (rib_pc_addr_o),
    .rib_pc_gnt_i      (rib_pc_gnt_i),
    .rib_pc_rvalid_i   (rib_pc_rvalid_i),
    .rib_pc_data_i     (rib_pc_data_i),
    .inst_valid_o      (inst_valid_o),
    .inst_o            (inst_o),
    .inst_addr_o       (inst_addr_o),
    .inst_ready_i      (inst_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } bus_req_t;

  bus_req_t    bq[$];
  int          n_assert;
  int          n_fail;
  int          cyc;
  int          last_due;
  int          grants;
  int          pops;
  logic [31:0] exp_addr;
  logic [31:0] last_pop_addr;
  logic        last_req;
  logic        last_valid;
  logic [31:0] last_inst_addr;
  logic [31:0] last_req_addr;

  bit          drv_rst;
  bit          drv_gnt;
  bit          drv_ready;
  bit          drv_halt;
  bit          drv_jump;
  bit          drv_jtag;
  logic [31:0] drv_jaddr;
  int          lat_fixed;
  bit          lat_rand;
  bit          rand_mode;

  // Instruction memory contents: a scrambled function of the word address
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1 time unit later, update the models
  task automatic step();
    bit rv;
    bit fl;
    int due;
    @(negedge clk);
    if (rand_mode) begin
      drv_gnt   = ($urandom_range(0, 9) < 6);
      drv_ready = ($urandom_range(0, 9) < 7);
      drv_halt  = ($urandom_range(0, 9) == 0);
      drv_jump  = ($urandom_range(0, 99) < 3);
      drv_jtag  = ($urandom_range(0, 99) == 0);
      drv_jaddr = $urandom();
    end
    if (drv_rst) begin
      bq.delete();
      last_due = 0;
    end
    rv                = !drv_rst && (bq.size() > 0) && (bq[0].due <= cyc);
    rst               = drv_rst;
    rib_pc_rvalid_i   = rv;
    rib_pc_data_i     = rv ? mem_word(bq[0].addr) : $urandom();
    rib_pc_gnt_i      = drv_gnt;
    inst_ready_i      = drv_ready;
    halt_i            = drv_halt;
    jump_flag_i       = drv_jump;
    jtag_reset_flag_i = drv_jtag;
    jump_addr_i       = drv_jaddr;
    #1;
    last_req       = rib_pc_req_o;
    last_valid     = inst_valid_o;
    last_inst_addr = inst_addr_o;
    last_req_addr  = rib_pc_addr_o;
    if (drv_rst) begin
      check("req_in_rst",   64'(rib_pc_req_o), 64'd0);
      check("valid_in_rst", 64'(inst_valid_o), 64'd0);
      check("nop_in_rst",   64'(inst_o),       64'(INST_NOP));
      exp_addr = RST_ADDR;
    end else begin
      fl = drv_jump || drv_jtag;
      if (!inst_valid_o) check("nop_when_idle", 64'(inst_o), 64'(INST_NOP));
      if (fl) begin
        check("valid_on_flush", 64'(inst_valid_o), 64'd0);
        check("req_on_flush",   64'(rib_pc_req_o), 64'd0);
      end
      if (drv_halt) check("req_on_halt", 64'(rib_pc_req_o), 64'd0);
      if (inst_valid_o && drv_ready) begin
        check("pop_addr", 64'(inst_addr_o), 64'(exp_addr));
        check("pop_inst", 64'(inst_o),      64'(mem_word(exp_addr)));
        last_pop_addr = inst_addr_o;
        exp_addr      = exp_addr + 32'd4;
        pops++;
      end
      if (fl) exp_addr = (drv_jtag ? RST_ADDR : drv_jaddr) & ~32'h3;
      if (rib_pc_req_o && drv_gnt) begin
        check("outstanding_limit", 64'(bq.size() < MAXO), 64'd1);
        check("req_aligned",       64'(rib_pc_addr_o[1:0]), 64'd0);
        due = cyc + 1 + (lat_rand ? int'($urandom_range(0, 3)) : lat_fixed);
        if (due < last_due) due = last_due;
        last_due = due;
        bq.push_back('{addr: rib_pc_addr_o, due: due});
        grants++;
      end
      if (rv) void'(bq.pop_front());
    end
    cyc++;
  endtask

  task automatic do_reset();
    drv_rst   = 1'b1;
    drv_jump  = 1'b0;
    drv_jtag  = 1'b0;
    drv_halt  = 1'b0;
    repeat (3) step();
    drv_rst   = 1'b0;
  endtask

  int g0;
  int p0;

  initial begin
    n_assert = 0; n_fail = 0; cyc = 0; last_due = 0; grants = 0; pops = 0;
    exp_addr = RST_ADDR; last_pop_addr = '0;
    drv_rst = 1'b1; drv_gnt = 1'b0; drv_ready = 1'b0; drv_halt = 1'b0;
    drv_jump = 1'b0; drv_jtag = 1'b0; drv_jaddr = '0;
    lat_fixed = 0; lat_rand = 1'b0; rand_mode = 1'b0;
    rst = 1'b1; jump_flag_i = 1'b0; jump_addr_i = '0; jtag_reset_flag_i = 1'b0;
    halt_i = 1'b0; rib_pc_gnt_i = 1'b0; rib_pc_rvalid_i = 1'b0; rib_pc_data_i = '0;
    inst_ready_i = 1'b0;

    // Streaming after reset: one instruction per cycle from cycle 3
    do_reset();
    drv_gnt = 1'b1; drv_ready = 1'b1; lat_fixed = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) begin
        check("first_req",        64'(last_req),       64'd1);
        check("first_req_addr",   64'(last_req_addr),  64'(RST_ADDR));
        check("reset_inst_addr",  64'(last_inst_addr), 64'(RST_ADDR));
      end
      if (k <= 2) check("no_bypass_valid", 64'(last_valid), 64'd0);
      if (k >= 3) begin
        check("stream_valid", 64'(last_valid),     64'd1);
        check("stream_addr",  64'(last_inst_addr), 64'(32'(4 * (k - 3))));
      end
    end

    // Decode stalled: exactly DEPTH entries fetched, then drained in order
    do_reset();
    drv_gnt = 1'b1; drv_ready = 1'b0; lat_fixed = 0;
    g0 = grants;
    repeat (12) step();
    check("hold_grants", 64'(grants - g0), 64'(DEPTH));
    check("hold_req",    64'(last_req),    64'd0);
    check("hold_valid",  64'(last_valid),  64'd1);
    p0 = pops;
    drv_ready = 1'b1;
    repeat (4) step();
    check("drain_count", 64'(pops - p0),    64'd4);
    check("drain_last",  64'(last_pop_addr), 64'h0000_000C);

    // Jump with two requests in flight: both responses dropped
    do_reset();
    drv_gnt = 1'b1; drv_ready = 1'b1; lat_fixed = 3;
    for (int i = 0; i < 10 && bq.size() < 2; i++) step();
    check("two_in_flight", 64'(bq.size()), 64'd2);
    drv_jump = 1'b1; drv_jaddr = 32'h0000_0103;
    step();
    check("jump_cycle_valid", 64'(last_valid), 64'd0);
    drv_jump = 1'b0;
    p0 = pops;
    for (int i = 0; i < 30 && pops == p0; i++) step();
    check("jump_pop_seen", 64'(pops > p0),     64'd1);
    check("jump_target",   64'(last_pop_addr), 64'h0000_0100);

    // JTAG reset and jump together: JTAG wins
    drv_jump = 1'b1; drv_jtag = 1'b1; drv_jaddr = 32'h0000_0200;
    step();
    drv_jump = 1'b0; drv_jtag = 1'b0;
    p0 = pops;
    for (int i = 0; i < 30 && pops == p0; i++) step();
    check("jtag_pop_seen", 64'(pops > p0),     64'd1);
    check("jtag_target",   64'(last_pop_addr), 64'(RST_ADDR));

    // Address wrap from the top word back to zero
    drv_jump = 1'b1; drv_jaddr = 32'hFFFF_FFF8; lat_fixed = 0;
    step();
    drv_jump = 1'b0;
    p0 = pops;
    for (int i = 0; i < 30 && pops < p0 + 3; i++) step();
    check("wrap_pops", 64'(pops - p0),     64'd3);
    check("wrap_addr", 64'(last_pop_addr), 64'd0);

    // Halt mid-stream: in-flight responses land, no new requests, sequential resume
    lat_rand = 1'b1;
    repeat (10) step();
    drv_halt = 1'b1;
    g0 = grants;
    repeat (10) step();
    check("halt_grants",  64'(grants - g0), 64'd0);
    check("halt_landed",  64'(bq.size()),   64'd0);
    drv_halt = 1'b0;
    p0 = pops;
    repeat (10) step();
    check("halt_resumed", 64'(pops > p0), 64'd1);

    // Randomized traffic against the reference stream
    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    drv_halt = 1'b0; drv_jump = 1'b0; drv_jtag = 1'b0; drv_gnt = 1'b1; drv_ready = 1'b1;
    p0 = pops;
    repeat (20) step();
    check("final_progress", 64'(pops > p0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
